// File: rtl/sync_pkg.sv
// Shared helpers for clock-domain-crossing synchronizers: Gray/binary
// conversion, one-hot detection and the legal range of chain depths.
package sync_pkg;

  // Shortest chain that still gives a metastable first flop a full cycle to settle.
  localparam int SYNC_STAGES_MIN = 2;
  // Deeper chains only add latency to the FIFO full/empty flags.
  localparam int SYNC_STAGES_MAX = 4;
  // Working width of the helper functions. Narrower vectors are zero-extended
  // on the way in and truncated on the way out by the caller.
  localparam int SYNC_FN_W = 32;

  // Gray to binary conversion: b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i].
  // Zero-extension of a narrower code leaves the low bits unchanged, so one
  // function serves every pointer width up to SYNC_FN_W.
  function automatic logic [SYNC_FN_W-1:0] gray2bin(input logic [SYNC_FN_W-1:0] g);
    logic [SYNC_FN_W-1:0] b;
    b[SYNC_FN_W-1] = g[SYNC_FN_W-1];
    for (int i = SYNC_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when exactly one bit of x is set.
  function automatic logic is_onehot(input logic [SYNC_FN_W-1:0] x);
    return (x != '0) && ((x & (x - SYNC_FN_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Generic multi-flop synchronizer. Plain flop-to-flop chain with no logic
// between stages, so it is also usable for single-bit flags.
module sync_ff_chain
  import sync_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("sync_ff_chain: STAGES=%0d is below the minimum of %0d", STAGES, SYNC_STAGES_MIN);
  end

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the far-domain value one flop per local edge; stage[0] may go metastable.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_ptr_gray_chk.sv
// Gray pointer synchronizer for the async FIFO with Gray-rule checking.
// The pointer crosses through sync_ff_chain; the synchronized sample is then
// compared against the last accepted sample, and legal steps update a
// registered binary copy plus a one-cycle update strobe. Multi-bit jumps set
// a sticky error flag and, with HOLD_ON_ERR=1, are kept out of sync_bin.
module sync_ptr_gray_chk
  import sync_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int STAGES      = 2,
  parameter bit HOLD_ON_ERR = 1'b1
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic [ADDRSIZE:0] ptr_gray,
  input  logic              err_clr,
  output logic [ADDRSIZE:0] sync_gray,
  output logic [ADDRSIZE:0] sync_bin,
  output logic              ptr_upd,
  output logic              gray_err
);

  localparam int PW = ADDRSIZE + 1;

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_ptr_gray_chk: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end
  if (PW > SYNC_FN_W) begin : g_bad_width
    $error("sync_ptr_gray_chk: pointer width %0d exceeds %0d", PW, SYNC_FN_W);
  end

  logic [PW-1:0] prev_gray;
  logic [PW-1:0] diff;
  logic [PW-1:0] bin_next;
  logic          no_chg;
  logic          step_ok;
  logic          viol;
  logic          accept;

  // ---- synchronizer chain: ptr_gray -> sync_gray, STAGES edges ----
  sync_ff_chain #(
    .WIDTH  (PW),
    .STAGES (STAGES)
  ) u_chain (
    .wclk (wclk),
    .wrst (wrst),
    .d    (ptr_gray),
    .q    (sync_gray)
  );

  // Classify the synchronized sample against the last accepted one.
  always_comb begin
    diff     = sync_gray ^ prev_gray;
    bin_next = PW'(gray2bin(SYNC_FN_W'(sync_gray)));
    no_chg   = (diff == '0);
    step_ok  = is_onehot(SYNC_FN_W'(diff));
    viol     = !no_chg && !step_ok;
    accept   = step_ok || (viol && !HOLD_ON_ERR);
  end

  // ---- accept stage: one edge after sync_gray ----
  // Commit the accepted sample; ptr_upd marks the single cycle sync_bin moved.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      prev_gray <= '0;
      sync_bin  <= '0;
      ptr_upd   <= 1'b0;
    end else begin
      ptr_upd <= accept;
      if (accept) begin
        prev_gray <= sync_gray;
        sync_bin  <= bin_next;
      end
    end
  end

  // Sticky error flag; a violation in the same cycle as err_clr keeps it set.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      gray_err <= 1'b0;
    end else if (viol) begin
      gray_err <= 1'b1;
    end else if (err_clr) begin
      gray_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_ptr_gray_chk.sv
// Bench for sync_ptr_gray_chk: two instances (STAGES=2/HOLD_ON_ERR=1 and
// STAGES=3/HOLD_ON_ERR=0) share one stimulus stream. A reference model
// predicts each instance's outputs per edge into a queue; a monitor pops
// and compares after every rising edge.
module tb_sync_ptr_gray_chk;

  typedef struct packed {
    logic [4:0] sg;
    logic [4:0] sb;
    logic       upd;
    logic       err;
  } exp_t;

  logic       wclk;
  logic       wrst;
  logic [4:0] ptr_gray;
  logic       err_clr;
  logic [4:0] sg0, sb0, sg1, sb1;
  logic       upd0, err0, upd1, err1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   upd_cnt0 = 0;
  int   upd_cnt1 = 0;
  bit   mon_en = 1'b0;
  logic [4:0] cur;

  // Reference model state, per instance
  int         m_stages[2] = '{2, 3};
  bit         m_hold[2]   = '{1'b1, 1'b0};
  logic [4:0] m_dly[2][4];
  logic [4:0] m_prev[2];
  logic [4:0] m_bin[2];
  logic       m_upd[2];
  logic       m_err[2];
  int         g2b[32];

  sync_ptr_gray_chk #(.ADDRSIZE(4), .STAGES(2), .HOLD_ON_ERR(1'b1)) dut0 (
    .wclk(wclk), .wrst(wrst), .ptr_gray(ptr_gray), .err_clr(err_clr),
    .sync_gray(sg0), .sync_bin(sb0), .ptr_upd(upd0), .gray_err(err0)
  );

  sync_ptr_gray_chk #(.ADDRSIZE(4), .STAGES(3), .HOLD_ON_ERR(1'b0)) dut1 (
    .wclk(wclk), .wrst(wrst), .ptr_gray(ptr_gray), .err_clr(err_clr),
    .sync_gray(sg1), .sync_bin(sb1), .ptr_upd(upd1), .gray_err(err1)
  );

  initial begin
    wclk = 1'b1;
    forever #5 wclk = ~wclk;
  end

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) m_dly[i][k] = '0;
      m_prev[i] = '0;
      m_bin[i]  = '0;
      m_upd[i]  = 1'b0;
      m_err[i]  = 1'b0;
    end
  endfunction

  // Predict the outputs after the coming rising edge from the inputs now applied.
  function automatic void model_edge();
    exp_t e;
    if (wrst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [4:0] seen;
        int         nbits;
        bit         bad;
        bit         take;
        seen  = m_dly[i][m_stages[i]-1];
        nbits = $countones(seen ^ m_prev[i]);
        bad   = (nbits > 1);
        take  = (nbits == 1) || (bad && !m_hold[i]);
        if (take) begin
          m_prev[i] = seen;
          m_bin[i]  = 5'(g2b[seen]);
        end
        m_upd[i] = take;
        if (bad) m_err[i] = 1'b1;
        else if (err_clr) m_err[i] = 1'b0;
        for (int k = 3; k > 0; k--) m_dly[i][k] = m_dly[i][k-1];
        m_dly[i][0] = ptr_gray;
      end
    end
    e = '{sg: m_dly[0][m_stages[0]-1], sb: m_bin[0], upd: m_upd[0], err: m_err[0]};
    q0.push_back(e);
    e = '{sg: m_dly[1][m_stages[1]-1], sb: m_bin[1], upd: m_upd[1], err: m_err[1]};
    q1.push_back(e);
  endfunction

  task automatic cyc(input logic [4:0] g, input logic clr, input logic r);
    @(negedge wclk);
    ptr_gray = g;
    err_clr  = clr;
    wrst     = r;
    model_edge();
    mon_en = 1'b1;
  endtask

  // Assert reset between edges and confirm every output drops without a clock.
  task automatic async_reset_check();
    @(posedge wclk);
    #3;
    wrst = 1'b1;
    #1;
    chk("arst.d0.sync_gray", sg0, 5'd0);
    chk("arst.d0.sync_bin", sb0, 5'd0);
    chk("arst.d0.ptr_upd", 5'(upd0), 5'd0);
    chk("arst.d0.gray_err", 5'(err0), 5'd0);
    chk("arst.d1.sync_gray", sg1, 5'd0);
    chk("arst.d1.sync_bin", sb1, 5'd0);
    chk("arst.d1.ptr_upd", 5'(upd1), 5'd0);
    chk("arst.d1.gray_err", 5'(err1), 5'd0);
    model_reset();
  endtask

  // Monitor: after each rising edge compare both instances with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (mon_en) begin
        if (q0.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL d0.scoreboard_empty at %0t", $time);
        end else begin
          e = q0.pop_front();
          chk("d0.sync_gray", sg0, e.sg);
          chk("d0.sync_bin", sb0, e.sb);
          chk("d0.ptr_upd", 5'(upd0), 5'(e.upd));
          chk("d0.gray_err", 5'(err0), 5'(e.err));
        end
        if (q1.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL d1.scoreboard_empty at %0t", $time);
        end else begin
          e = q1.pop_front();
          chk("d1.sync_gray", sg1, e.sg);
          chk("d1.sync_bin", sb1, e.sb);
          chk("d1.ptr_upd", 5'(upd1), 5'(e.upd));
          chk("d1.gray_err", 5'(err1), 5'(e.err));
        end
        if (upd0 === 1'b1) upd_cnt0++;
        if (upd1 === 1'b1) upd_cnt1++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int sel;
    logic clr_r;
    logic rst_r;
    for (int n = 0; n < 32; n++) g2b[n ^ (n >> 1)] = n;
    wrst     = 1'b1;
    ptr_gray = '0;
    err_clr  = 1'b0;
    model_reset();

    // Power-on reset then release
    repeat (3) cyc(5'b00000, 1'b0, 1'b1);
    repeat (2) cyc(5'b00000, 1'b0, 1'b0);

    // Latency of a single step
    repeat (6) cyc(5'b00001, 1'b0, 1'b0);

    // Build nonzero state, then reset mid-cycle while ptr_gray is nonzero
    repeat (6) cyc(5'b10110, 1'b0, 1'b0);
    async_reset_check();
    repeat (2) cyc(5'b10110, 1'b0, 1'b1);
    repeat (3) cyc(5'b00000, 1'b0, 1'b0);

    // Full Gray count 1..31 then wrap to 0, one step per 4 cycles
    upd_cnt0 = 0;
    upd_cnt1 = 0;
    for (int k = 1; k <= 32; k++) begin
      b = k % 32;
      repeat (4) cyc(5'(b ^ (b >> 1)), 1'b0, 1'b0);
    end
    repeat (5) cyc(5'b00000, 1'b0, 1'b0);
    @(posedge wclk);
    #2;
    chk_int("sweep.d0.upd_pulses", upd_cnt0, 32);
    chk_int("sweep.d1.upd_pulses", upd_cnt1, 32);

    // Violation: accept 00001, jump to 00111, then legal 00011
    repeat (4) cyc(5'b00001, 1'b0, 1'b0);
    repeat (4) cyc(5'b00111, 1'b0, 1'b0);
    repeat (4) cyc(5'b00011, 1'b0, 1'b0);

    // err_clr with no violation
    cyc(5'b00011, 1'b1, 1'b0);
    repeat (3) cyc(5'b00011, 1'b0, 1'b0);

    // err_clr coinciding with violations
    cyc(5'b01101, 1'b0, 1'b0);
    repeat (2) cyc(5'b10110, 1'b0, 1'b0);
    repeat (3) cyc(5'b10110, 1'b1, 1'b0);
    repeat (4) cyc(5'b00010, 1'b0, 1'b0);
    repeat (2) cyc(5'b00010, 1'b1, 1'b0);
    repeat (2) cyc(5'b00010, 1'b0, 1'b0);

    // Randomized traffic: mostly single-bit steps, some jumps, clears and resets
    cur = 5'b00010;
    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 15));
      if (sel < 10) cur = cur ^ 5'(1 << $urandom_range(0, 4));
      else if (sel < 12) cur = 5'($urandom);
      clr_r = ($urandom_range(0, 7) == 0);
      rst_r = ($urandom_range(0, 99) == 0);
      repeat ($urandom_range(1, 3)) cyc(cur, clr_r, rst_r);
    end
    repeat (5) cyc(cur, 1'b0, 1'b0);
    @(posedge wclk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_ptr_gray_chk.md
Name: sync_ptr_gray_chk

Overview:
- Parametrised successor to the two-flop Gray pointer synchronizer used in the async FIFO.
- Synchronizes a Gray-coded pointer from the far clock domain into the local (wclk) domain through a configurable-depth flop chain.
- Also supplies, all registered: a binary copy of the pointer, an update strobe, and a sticky Gray-coding error flag.
- Sits in the FIFO's full/empty logic, one instance per crossing direction.

Parameters:
- ADDRSIZE, 4, FIFO address bits; pointer width is ADDRSIZE+1.
- STAGES, 2, synchronizer flop count; legal range 2..4, elaboration error otherwise.
- HOLD_ON_ERR, 1, 1 = a sample violating the Gray rule is not accepted into the binary/strobe outputs; 0 = all samples are accepted.

Ports:
- wclk  input  1  local-domain clock; all flops on rising edge.
- wrst  input  1  reset, asynchronous assert, active-high; clears all state.
- ptr_gray  input  ADDRSIZE+1  Gray pointer from the far domain (e.g. rptr); asynchronous to wclk.
- err_clr  input  1  synchronous clear of gray_err.
- sync_gray  output  ADDRSIZE+1  last stage of the synchronizer chain (direct replacement for wq2_rptr).
- sync_bin  output  ADDRSIZE+1  binary value of the last accepted Gray sample.
- ptr_upd  output  1  one-cycle pulse when sync_bin changes value.
- gray_err  output  1  sticky flag: a sample differed from the previous accepted sample in more than one bit.

Behaviour:
- Reset (wrst=1, async): every chain stage, sync_gray, sync_bin, the previous-accepted-Gray register, ptr_upd and gray_err go to 0 immediately. Outputs stay 0 while wrst is held.
- Chain: stage[0] <= ptr_gray; stage[i] <= stage[i-1]; sync_gray = stage[STAGES-1].
  - Latency: a stable input change reaches sync_gray STAGES wclk edges later, with up to +1 edge of metastability uncertainty.
  - No logic is allowed between chain stages.
- Check, combinational on sync_gray versus prev_gray (last accepted sample, reset 0), with diff = sync_gray XOR prev_gray:
  - diff == 0: no change.
  - diff one-hot: valid step.
  - otherwise: violation.
- Accept register, one cycle after sync_gray:
  - Valid step: prev_gray <= sync_gray, sync_bin <= gray2bin(sync_gray), ptr_upd <= 1.
  - No change: hold; ptr_upd <= 0.
  - Violation, HOLD_ON_ERR=1: hold prev_gray and sync_bin; ptr_upd <= 0; gray_err <= 1.
  - Violation, HOLD_ON_ERR=0: accept as for a valid step (ptr_upd <= 1); gray_err <= 1.
- Total latency, input to sync_bin/ptr_upd: STAGES+1 edges.
- Wrap-around: Gray wrap (binary 2^(ADDRSIZE+1)-1 -> 0) is a single-bit change. It is legal, and sync_bin wraps to 0 with ptr_upd=1.
- gray_err is sticky.
  - It clears on a clock edge with err_clr=1 and no new violation in that cycle.
  - When err_clr=1 and a violation occur in the same cycle, set wins (gray_err stays 1).
- gray2bin: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]. Pure combinational, registered only at sync_bin.
- Reset mid-operation: all state returns to 0. The first post-reset sample is compared against 0; a nonzero multi-bit value flags gray_err.
- Operating rule: the far domain must reset together with this block, otherwise spurious gray_err is expected.

Decomposition:
- Package sync_pkg:
  - function gray2bin(width-generic);
  - function is_onehot;
  - constant SYNC_STAGES_MIN=2.
- Sub-module sync_ff_chain (params WIDTH, STAGES; ports wclk, wrst, d, q): the generic multi-flop synchronizer, reused for single-bit flags elsewhere.
- The checker and accept registers stay in sync_ptr_gray_chk.

Test Plan:
- Reset: drive ptr_gray=5'b10110, assert wrst mid-cycle -> all outputs 0 asynchronously; hold at 0 until the first edge after release.
- Latency (STAGES=2, ADDRSIZE=4): ptr_gray 00000->00001 -> sync_gray=00001 after 2 edges; sync_bin=1 and ptr_upd=1 for exactly 1 cycle after edge 3. Repeat with STAGES=3 -> edges 3 and 4.
- Full count: step through Gray codes for binary 0..31 and then back to 0, one step per 4 cycles -> sync_bin follows 0..31 then 0, 32 ptr_upd pulses, gray_err=0 throughout.
- Violation, HOLD_ON_ERR=1: accepted 00001, then input 00111 -> gray_err=1, sync_bin stays 1, no ptr_upd. Then input 00011 (one bit from 00001) -> accepted, sync_bin=2, gray_err stays 1.
- Violation, HOLD_ON_ERR=0: same stimulus -> sync_bin=5 (gray2bin(00111)), ptr_upd=1, gray_err=1.
- err_clr: pulse err_clr with no violation -> gray_err=0 next edge. Pulse err_clr in the same cycle as a new violation -> gray_err remains 1.
